// File: rtl/blink_pkg.sv
// Shared definitions for the blink round controller: state geometry,
// FSM encoding and the default round-constant width.
package blink_pkg;

  localparam int STATE_W      = 128;
  localparam int CELL_W       = 4;
  localparam int ROWS         = 4;
  localparam int ROW_W        = STATE_W / ROWS;
  localparam int COLS         = ROW_W / CELL_W;
  localparam int RC_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } blink_state_e;

endpackage

// File: rtl/blink_mix_columns.sv
// Column diffusion: each output cell in a column is the XOR of the other
// three cells of that column, which makes the mapping its own inverse.
module blink_mix_columns
  import blink_pkg::*;
(
  input  logic [STATE_W-1:0] din,
  output logic [STATE_W-1:0] dout
);

  always_comb begin
    dout = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < ROWS; j++) begin
          if (j != i) begin
            dout[i*ROW_W + c*CELL_W +: CELL_W] =
              dout[i*ROW_W + c*CELL_W +: CELL_W] ^ din[j*ROW_W + c*CELL_W +: CELL_W];
          end
        end
      end
    end
  end

endmodule

// File: rtl/blink_round_ctrl.sv
// Round controller: accepts one job, applies key/round-constant mixing plus
// column diffusion once per cycle, then holds the result until consumed.
module blink_round_ctrl
  import blink_pkg::*;
#(
  parameter int MAX_ROUNDS = 16,
  parameter int RC_W       = RC_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [STATE_W-1:0]  in_data,
  input  logic [STATE_W-1:0]  in_key,
  input  logic [4:0]          in_rounds,
  input  logic                rc_en,
  input  logic                abort,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [STATE_W-1:0]  out_data,
  output logic                busy,
  output logic [4:0]          round_cnt
);

  blink_state_e       state_q;
  logic [STATE_W-1:0] data_q;
  logic [STATE_W-1:0] key_q;
  logic [4:0]         rounds_q;
  logic               rc_en_q;

  logic [4:0]         rounds_clamped;
  logic [STATE_W-1:0] rc_vec;
  logic [STATE_W-1:0] mix_in;
  logic [STATE_W-1:0] mix_out;
  logic               last_round;

  assign rounds_clamped = (in_rounds > 5'(MAX_ROUNDS)) ? 5'(MAX_ROUNDS) : in_rounds;
  assign last_round     = ({1'b0, round_cnt} + 6'd1) == {1'b0, rounds_q};

  // The round constant is the 1-based index of the round being computed.
  always_comb begin
    rc_vec = '0;
    if (rc_en_q) begin
      rc_vec[RC_W-1:0] = RC_W'({1'b0, round_cnt} + 6'd1);
    end
  end

  assign mix_in = data_q ^ key_q ^ rc_vec;

  blink_mix_columns u_mix (
    .din  (mix_in),
    .dout (mix_out)
  );

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == RUN) || (state_q == DONE);
  assign out_data = data_q;

  // out_valid is registered one cycle after entering DONE; abort always wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      key_q     <= '0;
      rounds_q  <= '0;
      rc_en_q   <= 1'b0;
      round_cnt <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q    <= in_data;
            key_q     <= in_key;
            rounds_q  <= rounds_clamped;
            rc_en_q   <= rc_en;
            round_cnt <= '0;
            out_valid <= 1'b0;
            state_q   <= (rounds_clamped != 5'd0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            data_q    <= mix_out;
            round_cnt <= round_cnt + 5'd1;
            if (last_round) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (abort || (out_valid && out_ready)) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/blink_round_ctrl.md
BLINK_ROUND_CTRL -- requirements
Module: blink_round_ctrl

Interface
REQ-001 Parameter: MAX_ROUNDS, 16, largest accepted round count; in_rounds values above it are clamped to MAX_ROUNDS.
REQ-002 Parameter: RC_W, 8, width of the round constant injected into state bits [RC_W-1:0].
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  job offered.
REQ-006 in_ready  output  1  controller can accept a job; high exactly in IDLE.
REQ-007 in_data  input  128  initial cipher state (32 cells of 4 bits).
REQ-008 in_key  input  128  round key, constant for the whole job.
REQ-009 in_rounds  input  5  number of rounds to apply, 0..MAX_ROUNDS.
REQ-010 rc_en  input  1  enables round-constant injection; sampled with the job.
REQ-011 abort  input  1  synchronous abort; drops the current job.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_data  output  128  result state.
REQ-015 busy  output  1  high in RUN or DONE.
REQ-016 round_cnt  output  5  rounds completed in the current job.

Function
REQ-017 FSM states: IDLE, RUN, DONE.
REQ-018 IDLE: when in_valid and in_ready are both high, latch in_data, in_key, clamped in_rounds and rc_en, and clear round_cnt; go to RUN if rounds > 0, otherwise go to DONE with out_data = in_data.
REQ-019 RUN, each cycle: state <= D(state ^ key ^ rc), where D is the 128-bit column diffusion; round_cnt increments by 1.
REQ-020 rc: when rc_en = 1, value (round_cnt+1) zero-extended to RC_W in bits [RC_W-1:0], zeros elsewhere; when rc_en = 0, all zeros.
REQ-021 D per column c (0..7): the cells at bit offsets 4c, 32+4c, 64+4c, 96+4c form rows 0..3; output row i = XOR of the three input rows other than i.
REQ-022 RUN -> DONE in the cycle where round_cnt+1 equals the latched rounds; out_valid rises the next cycle.
REQ-023 Latency: a job accepted at edge t with N >= 1 rounds raises out_valid after edge t+N+1. With N = 0, out_valid rises after edge t+1.
REQ-024 DONE: out_valid is held high and out_data is held stable until out_ready is high; that handshake edge returns the FSM to IDLE and clears out_valid.
REQ-025 No job overlap: in_ready is low in RUN and DONE, even while out_ready is high.
REQ-026 abort high in RUN or DONE: return to IDLE on the next edge, clear out_valid, and produce no output; abort high in IDLE has no effect.
REQ-027 abort has priority over completion and over the output handshake in the same cycle.
REQ-028 round_cnt holds its final value in DONE and is cleared on the next accept.

Reset
REQ-029 rst forces state IDLE, out_valid 0, out_data 0, round_cnt 0, busy 0 and internal registers 0, immediately and independent of clk.
REQ-030 in_ready is 1 from reset release onward.
REQ-031 Reset asserted mid-RUN discards the job, and no out_valid pulse follows.

Structure
REQ-032 Shared package blink_pkg holds STATE_W = 128, CELL_W = 4, the FSM state enum, and the RC_W default.
REQ-033 The diffusion D is one instantiated sub-module, the existing MixColumns block; blink_round_ctrl holds only the FSM, counter, key/state registers and the XOR logic.

Verification
REQ-034 in_data = 0, in_key = 0, rc_en = 1, rounds = 1 -> out_data = 128'h00000001_00000001_00000001_00000000, with out_valid 2 cycles after accept.
REQ-035 in_data = 128'h0123456789ABCDEF_FEDCBA9876543210, key = 0, rc_en = 0, rounds = 2 -> out_data equals in_data (D is an involution), with out_valid 3 cycles after accept.
REQ-036 rounds = 0, in_data = 128'hA5...A5 -> out_data = in_data, with out_valid 1 cycle after accept.
REQ-037 Job with rounds = 4 and out_ready held low for 5 cycles after out_valid -> out_valid and out_data stable throughout, in_ready 0, IDLE one cycle after out_ready rises.
REQ-038 rounds = 8, rst pulsed after round 3 -> all outputs 0 and in_ready 1 after release; a new job then completes normally.
REQ-039 rounds = 8, abort at round 5 -> IDLE next cycle with no out_valid; abort and out_ready together in DONE -> no handshake is counted.
